serial_frame_reader: RTL

SERIAL_FRAME_READER -- requirements
Module: serial_frame_reader

---
 rtl/serial_frame_reader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_frame_reader.sv
// serial_frame_reader: brings a host serial port (SCLK/SDIO/FRAME_N) into the CLK domain
// and assembles fixed-length frames, reporting short, timeout and overrun errors.

module serial_frame_reader #(
    parameter int FRAME_BITS     = 184,
    parameter int SYNC_STAGES    = 2,
    parameter int MSB_FIRST      = 1,
    parameter int USE_FRAME      = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  SCLK_PE3,
    input  logic                  SDIO_PE5,
    input  logic                  FRAME_N_PE4,
    output logic [FRAME_BITS-1:0] DATA_OUT,
    output logic                  FRAME_VALID,
    output logic                  FRAME_ERR,
    output logic [1:0]            ERR_CODE,
    output logic [15:0]           FRAME_COUNT,
    output logic                  BUSY
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit USE_FR = (USE_FRAME != 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OVERRUN
    } state_t;

    logic [1:0]             rstPipe_q;
    logic                   rstSync_n;
    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] sdioSync_q;
    logic [SYNC_STAGES-1:0] frameSync_q;
    logic                   sclkPrev_q;
    logic                   framePrev_q;

    state_t                 state_q;
    logic [FRAME_BITS-1:0]  assembly_q;
    logic [FRAME_BITS-1:0]  assembly_d;
    logic [CNT_W-1:0]       bitCount_q;
    logic [TO_W-1:0]        timeout_q;
    logic                   overrunFlagged_q;
    logic [FRAME_BITS-1:0]  dataOut_q;
    logic                   frameValid_q;
    logic                   frameErr_q;
    logic [1:0]             errCode_q;
    logic [15:0]            frameCount_q;
    logic                   busy_q;

    logic sclkS;
    logic sdioS;
    logic frameS;
    logic sclkEdge;
    logic frameFall;
    logic frameRise;
    logic lastBit;
    logic timeoutHit;

    // Reset asserts asynchronously but is released only on a CLK edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rstPipe_q <= '0;
        end else begin
            rstPipe_q <= {rstPipe_q[0], 1'b1};
        end
    end

    assign rstSync_n = rstPipe_q[1];

    always_ff @(posedge CLK or negedge rstSync_n) begin
        if (!rstSync_n) begin
            sclkSync_q  <= '0;
            sdioSync_q  <= '0;
            frameSync_q <= '0;
            sclkPrev_q  <= 1'b0;
            framePrev_q <= 1'b0;
        end else begin
            sclkSync_q  <= {sclkSync_q[SYNC_STAGES-2:0], SCLK_PE3};
            sdioSync_q  <= {sdioSync_q[SYNC_STAGES-2:0], SDIO_PE5};
            frameSync_q <= {frameSync_q[SYNC_STAGES-2:0], FRAME_N_PE4};
            sclkPrev_q  <= sclkSync_q[SYNC_STAGES-1];
            framePrev_q <= frameSync_q[SYNC_STAGES-1];
        end
    end

    assign sclkS      = sclkSync_q[SYNC_STAGES-1];
    assign sdioS      = sdioSync_q[SYNC_STAGES-1];
    assign frameS     = frameSync_q[SYNC_STAGES-1];
    assign sclkEdge   = sclkS & ~sclkPrev_q;
    assign frameFall  = ~frameS & framePrev_q;
    assign frameRise  = frameS & ~framePrev_q;
    assign lastBit    = (bitCount_q == LAST_BIT);
    // An empty frame (no bits yet) is not "in progress", so it never times out.
    assign timeoutHit = (bitCount_q != '0) && (timeout_q == TO_LAST);

    always_comb begin
        assembly_d = assembly_q;
        if (MSB_FIRST != 0) begin
            assembly_d = {assembly_q[FRAME_BITS-2:0], sdioS};
        end else begin
            assembly_d = {sdioS, assembly_q[FRAME_BITS-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge rstSync_n) begin
        if (!rstSync_n) begin
            state_q          <= IDLE;
            assembly_q       <= '0;
            bitCount_q       <= '0;
            timeout_q        <= '0;
            overrunFlagged_q <= 1'b0;
            dataOut_q        <= '0;
            frameValid_q     <= 1'b0;
            frameErr_q       <= 1'b0;
            errCode_q        <= 2'b00;
            frameCount_q     <= '0;
            busy_q           <= 1'b0;
        end else begin
            frameValid_q <= 1'b0;
            frameErr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (USE_FR) begin
                        if (frameFall) begin
                            state_q    <= SHIFT;
                            bitCount_q <= '0;
                            timeout_q  <= '0;
                            busy_q     <= 1'b1;
                        end
                    end else if (sclkEdge) begin
                        assembly_q <= assembly_d;
                        bitCount_q <= CNT_W'(1);
                        timeout_q  <= '0;
                        state_q    <= SHIFT;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sclkEdge) begin
                        assembly_q <= assembly_d;
                        timeout_q  <= '0;
                        if (lastBit) begin
                            dataOut_q        <= assembly_d;
                            frameValid_q     <= 1'b1;
                            frameCount_q     <= frameCount_q + 16'd1;
                            bitCount_q       <= '0;
                            overrunFlagged_q <= 1'b0;
                            // OVERRUN leaves on FRAME_N high, which also covers a simultaneous release.
                            if (USE_FR) begin
                                state_q <= OVERRUN;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bitCount_q <= bitCount_q + CNT_W'(1);
                        end
                    end else if (USE_FR && frameRise) begin
                        frameErr_q <= 1'b1;
                        errCode_q  <= 2'b01;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end else if (timeoutHit) begin
                        frameErr_q <= 1'b1;
                        errCode_q  <= 2'b10;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end else if (bitCount_q != '0) begin
                        timeout_q <= timeout_q + TO_W'(1);
                    end
                end
                OVERRUN: begin
                    busy_q <= 1'b0;
                    if (frameS) begin
                        state_q <= IDLE;
                    end else if (sclkEdge && !overrunFlagged_q) begin
                        frameErr_q       <= 1'b1;
                        errCode_q        <= 2'b11;
                        overrunFlagged_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DATA_OUT    = dataOut_q;
    assign FRAME_VALID = frameValid_q;
    assign FRAME_ERR   = frameErr_q;
    assign ERR_CODE    = errCode_q;
    assign FRAME_COUNT = frameCount_q;
    assign BUSY        = busy_q;

endmodule
